// File: rtl/fpu_pkg.sv
// Shared single-precision FPU constants, flag bit positions and rounding modes.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fpu_pkg;

    localparam int          FP_EXP_BIAS = 127;
    localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
    localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;

    // Bit positions inside the 4-bit {invalid, overflow, underflow, inexact} flag word
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef enum logic [1:0] {
        RND_RNE = 2'b00,
        RND_RTZ = 2'b01,
        RND_RUP = 2'b10,
        RND_RDN = 2'b11
    } rnd_mode_t;

endpackage

// File: rtl/fp_round_rne.sv
// Rounds a 23-bit fraction using guard/sticky bits under the selected rounding mode.
// Latency: purely combinational.
// Backpressure: none; the caller owns all handshaking.
module fp_round_rne
    import fpu_pkg::*;
(
    input  logic [22:0] m,
    input  logic        g,
    input  logic        s,
    input  logic        sign,
    input  rnd_mode_t   mode,
    output logic [22:0] m_rnd,
    output logic        carry,
    output logic        inexact
);

    logic inc;

    // Pick the increment for the mode, then add it with carry-out into the exponent
    always_comb begin
        inc = 1'b0;
        case (mode)
            RND_RNE: inc = g && (s || m[0]);
            RND_RTZ: inc = 1'b0;
            RND_RUP: inc = (g || s) && !sign;
            RND_RDN: inc = (g || s) && sign;
            default: inc = 1'b0;
        endcase
        {carry, m_rnd} = {1'b0, m} + {23'd0, inc};
        inexact        = g || s;
    end

endmodule

// File: rtl/fp_mul_round_pack.sv
// Normalises, rounds and packs a raw FP multiply product into binary32 with IEEE flags.
// Latency: 2 cycles input transfer to out_valid, 1 result per cycle, order preserved.
// Backpressure: out_ready low holds the output; in_ready = !s1_valid || (!out_valid || out_ready). Optional FP_ROUND_MODES_EN adds rnd_mode.
module fp_mul_round_pack
    import fpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int EXPW  = 10,
    parameter int MANTW = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic signed [EXPW-1:0] in_exp,
    input  logic [MANTW-1:0]       in_mant,
    input  logic                   in_zero,
    input  logic                   in_inf,
    input  logic                   in_nan,
`ifdef FP_ROUND_MODES_EN
    input  logic [1:0]             rnd_mode,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_result,
    output logic [3:0]             out_flags
);

    // One extra bit so in_exp+1 and the rounding carry can never wrap
    localparam int EW = EXPW + 1;
    localparam logic signed [EW-1:0] E_OVF  = EW'(255);
    localparam logic signed [EW-1:0] E_ZERO = '0;

    logic                 s1_adv;
    logic                 s1_valid;
    logic                 s1_sign, s1_g, s1_s, s1_zero, s1_inf, s1_nan;
    logic [22:0]          s1_m;
    logic signed [EW-1:0] s1_e;
    rnd_mode_t            s1_mode;

    logic [22:0]          n_m;
    logic                 n_g, n_s;
    logic signed [EW-1:0] n_e;

    logic [22:0]          r_m;
    logic                 r_carry, r_inexact;
    logic signed [EW-1:0] e_r;
    logic [XLEN-1:0]      res;
    logic [3:0]           flg;
    logic                 to_finite;

    assign s1_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s1_adv;

    // Normalise: product is in [1,4), so pick the 23 fraction bits below the leading one
    always_comb begin
        if (in_mant[47]) begin
            n_m = in_mant[46:24];
            n_g = in_mant[23];
            n_s = |in_mant[22:0];
            n_e = {in_exp[EXPW-1], in_exp} + EW'(1);
        end else begin
            n_m = in_mant[45:23];
            n_g = in_mant[22];
            n_s = |in_mant[21:0];
            n_e = {in_exp[EXPW-1], in_exp};
        end
    end

    // Stage 1 register: accepts a new beat whenever it is empty or draining
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_m    <= n_m;
                s1_g    <= n_g;
                s1_s    <= n_s;
                s1_e    <= n_e;
                s1_sign <= in_sign;
                s1_zero <= in_zero;
                s1_inf  <= in_inf;
                s1_nan  <= in_nan;
            end
        end
    end

`ifdef FP_ROUND_MODES_EN
    // Rounding mode travels with its beat
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            s1_mode <= rnd_mode_t'(rnd_mode);
        end
    end
    assign to_finite = (s1_mode == RND_RTZ) ||
                       (s1_mode == RND_RUP && s1_sign) ||
                       (s1_mode == RND_RDN && !s1_sign);
`else
    assign s1_mode   = RND_RNE;
    assign to_finite = 1'b0;
`endif

    fp_round_rne u_round (
        .m       (s1_m),
        .g       (s1_g),
        .s       (s1_s),
        .sign    (s1_sign),
        .mode    (s1_mode),
        .m_rnd   (r_m),
        .carry   (r_carry),
        .inexact (r_inexact)
    );

    // A fraction carry leaves m at zero (1.111.. -> 10.000..), so only e moves
    assign e_r = s1_e + {{(EW-1){1'b0}}, r_carry};

    // Special operands first, then exponent range, then the normal packed result
    always_comb begin
        res = {s1_sign, e_r[7:0], r_m};
        flg = 4'b0000;
        flg[FLAG_INEXACT] = r_inexact;
        if (s1_nan || (s1_inf && s1_zero)) begin
            res = FP_QNAN;
            flg = 4'b0000;
            flg[FLAG_INVALID] = 1'b1;
        end else if (s1_inf) begin
            res = {s1_sign, FP_EXP_MAX, 23'd0};
            flg = 4'b0000;
        end else if (s1_zero) begin
            res = {s1_sign, 31'd0};
            flg = 4'b0000;
        end else if (e_r >= E_OVF) begin
            res = to_finite ? {s1_sign, 8'hFE, {23{1'b1}}} : {s1_sign, FP_EXP_MAX, 23'd0};
            flg = 4'b0000;
            flg[FLAG_OVERFLOW] = 1'b1;
            flg[FLAG_INEXACT]  = 1'b1;
        end else if (e_r <= E_ZERO) begin
            res = {s1_sign, 31'd0};
            flg = 4'b0000;
            flg[FLAG_UNDERFLOW] = 1'b1;
            flg[FLAG_INEXACT]   = 1'b1;
        end
    end

    // Stage 2 / output register: holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (s1_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= res;
                out_flags  <= flg;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_round_pack.sv
// Directed-vector bench for fp_mul_round_pack with a scoreboard on the output port.
// Latency: checks the 2-cycle fill, then streams vectors back to back.
// Backpressure: exercises output stalls and a reset with both stages full.
module tb_fp_mul_round_pack;

    typedef struct {
        string       tag;
        logic        sign;
        logic [9:0]  exp;
        logic [47:0] mant;
        logic        zero;
        logic        inf;
        logic        nan;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [47:0] in_mant = '0;
    logic        in_zero = 1'b0;
    logic        in_inf = 1'b0;
    logic        in_nan = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
`ifdef FP_ROUND_MODES_EN
    logic [1:0]  rnd_mode = 2'b00;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];
    vec_t exp_q[$];
    vec_t bp[4];

    fp_mul_round_pack dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_zero    (in_zero),
        .in_inf     (in_inf),
        .in_nan     (in_nan),
`ifdef FP_ROUND_MODES_EN
        .rnd_mode   (rnd_mode),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic vec_t mk(input string tag, input logic sign, input logic [9:0] e,
                                input logic [47:0] mant, input logic z, input logic i,
                                input logic n, input logic [31:0] res, input logic [3:0] flg);
        vec_t v;
        v.tag = tag; v.sign = sign; v.exp = e; v.mant = mant;
        v.zero = z; v.inf = i; v.nan = n; v.res = res; v.flg = flg;
        return v;
    endfunction

    // Present a beat and record its expected result; caller advances the clock
    task automatic drive(input vec_t v);
        in_sign  = v.sign;
        in_exp   = v.exp;
        in_mant  = v.mant;
        in_zero  = v.zero;
        in_inf   = v.inf;
        in_nan   = v.nan;
        in_valid = 1'b1;
        exp_q.push_back(v);
    endtask

    // Present a beat and hold it until it transfers (bounded wait)
    task automatic send(input vec_t v);
        int n;
        drive(v);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check({v.tag, "_send_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1 check("drain", exp_q.size(), 0);
    endtask

    // Scoreboard: every presented output (stalled or not) must match the oldest expected beat
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("stale_out", {31'd0, out_valid}, 32'd0);
            end else begin
                check({exp_q[0].tag, "_res"}, out_result, exp_q[0].res);
                check({exp_q[0].tag, "_flg"}, {28'd0, out_flags}, {28'd0, exp_q[0].flg});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(mk("tie_carry", 0, 10'd127, 48'h7FFFFFC00000, 0, 0, 0, 32'h40000000, 4'b0001));
        vecs.push_back(mk("ovf",       0, 10'd254, 48'h900000000000, 0, 0, 0, 32'h7F800000, 4'b0101));
        vecs.push_back(mk("unf",       0, 10'h3FB, 48'h900000000000, 0, 0, 0, 32'h00000000, 4'b0011));
        vecs.push_back(mk("inf_zero",  0, 10'd127, 48'h400000000000, 1, 1, 0, 32'h7FC00000, 4'b1000));
        vecs.push_back(mk("neg_inf",   1, 10'd127, 48'h400000000000, 0, 1, 0, 32'hFF800000, 4'b0000));
        vecs.push_back(mk("neg_zero",  1, 10'd127, 48'h400000000000, 1, 0, 0, 32'h80000000, 4'b0000));
        vecs.push_back(mk("nan",       1, 10'd127, 48'h400000000000, 0, 0, 1, 32'h7FC00000, 4'b1000));
        vecs.push_back(mk("sticky",    0, 10'd127, 48'h400000000001, 0, 0, 0, 32'h3F800000, 4'b0001));
        vecs.push_back(mk("tie_even",  0, 10'd127, 48'h400000400000, 0, 0, 0, 32'h3F800000, 4'b0001));
        vecs.push_back(mk("tie_odd",   0, 10'd127, 48'h400000C00000, 0, 0, 0, 32'h3F800002, 4'b0001));
        vecs.push_back(mk("e_zero",    0, 10'd0,   48'h400000000000, 0, 0, 0, 32'h00000000, 4'b0011));
        vecs.push_back(mk("e_min",     0, 10'd1,   48'h400000000000, 0, 0, 0, 32'h00800000, 4'b0000));
        vecs.push_back(mk("e_max",     0, 10'd254, 48'h400000000000, 0, 0, 0, 32'h7F000000, 4'b0000));
        vecs.push_back(mk("carry_ovf", 0, 10'd254, 48'h7FFFFFC00000, 0, 0, 0, 32'h7F800000, 4'b0101));
        vecs.push_back(mk("neg_norm",  1, 10'd128, 48'h900000000000, 0, 0, 0, 32'hC0900000, 4'b0000));
        for (int i = 0; i < 4; i++)
            bp[i] = mk($sformatf("bp%0d", i), 0, 10'(100 + i), 48'h400000000000, 0, 0, 0,
                       32'h32000000 + 32'(i) * 32'h00800000, 4'b0000);

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_result",    out_result,         32'd0);
        check("rst_flags",     {28'd0, out_flags}, 32'd0);

        // 1.5*1.5 with exact latency
        @(posedge clk);
        #1 drive(mk("mul15", 0, 10'd127, 48'h900000000000, 0, 0, 0, 32'h40100000, 4'b0000));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_cycle2", {31'd0, out_valid}, 32'd1);
        drain();

        // Directed vectors streamed back to back
        foreach (vecs[i]) send(vecs[i]);
        drain();

        // Backpressure: 5 stalled cycles with 4 beats offered
        @(posedge clk);
        #1 out_ready = 1'b0;
        drive(bp[0]);
        @(posedge clk);
        #1 drive(bp[1]);
        @(posedge clk);
        #1 drive(bp[2]);
        @(negedge clk);
        check("bp_in_ready_drop", {31'd0, in_ready}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_held", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        #1 check("bp_in_ready_rel", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 drive(bp[3]);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        drive(mk("rst_a", 0, 10'd127, 48'h400000000000, 0, 0, 0, 32'h3F800000, 4'b0000));
        @(posedge clk);
        #1 drive(mk("rst_b", 0, 10'd128, 48'h400000000000, 0, 0, 0, 32'h40000000, 4'b0000));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("full_out_valid", {31'd0, out_valid}, 32'd1);
        check("full_in_ready",  {31'd0, in_ready},  32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("midrst_no_stale", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
